// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multicycle MIPS control unit:
//   - state_t     : controller FSM states (also driven out on the state probe)
//   - OP_*        : instruction[31:26] opcodes
//   - FN_*        : R-type instruction[5:0] function codes
//   - ALU_*       : alucontrol encodings understood by the datapath ALU
// ----------------------------------------------------------------------------
package mips_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SLL = 3'b011;
   localparam logic [2:0] ALU_SRL = 3'b100;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_aludec.sv
// ----------------------------------------------------------------------------
// mips_aludec
// Purely combinational R-type function decoder.
// Ports:
//   funct      in  6  instruction[5:0]
//   alucontrol out 3  ALU operation for the decoded funct (ADD when invalid)
//   valid      out 1  1 when funct is one of the supported R-type operations
// ----------------------------------------------------------------------------
module mips_aludec
   import mips_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alucontrol,
   output logic       valid
);

   // Unsupported codes still produce a defined ALU operation; the controller
   // uses valid to abort the instruction before any register write happens.
   always_comb begin
      alucontrol = ALU_ADD;
      valid      = 1'b1;
      case (funct)
         FN_ADD:  alucontrol = ALU_ADD;
         FN_SUB:  alucontrol = ALU_SUB;
         FN_AND:  alucontrol = ALU_AND;
         FN_OR:   alucontrol = ALU_OR;
         FN_SLT:  alucontrol = ALU_SLT;
         FN_SLL:  alucontrol = ALU_SLL;
         FN_SRL:  alucontrol = ALU_SRL;
         default: valid      = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_controller.sv
// ----------------------------------------------------------------------------
// mips_controller
// Multicycle MIPS control unit (Moore FSM with Mealy pcen / fault terms).
// Parameters:
//   TIMEOUT_CYCLES  cycles a memory state waits for memready (0 = never abort)
//   TW              width of the wait counter
// Ports:
//   clk, reset (async, active-low)
//   op, funct, zero        : instruction fields and ALU zero flag
//   memready               : memory finished the current access this cycle
//   memread, memwrite      : memory requests
//   pcen, irwrite, regwrite: datapath write enables (pcen branch-qualified)
//   iord, regdst, memtoreg, alusrca, alusrcb, pcsource, alucontrol : selects
//   illegal, memfault      : single-cycle error pulses
//   state                  : current FSM state for probing
// ----------------------------------------------------------------------------
module mips_controller
   import mips_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int TW             = 5
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       memready,
   output logic       memread,
   output logic       memwrite,
   output logic       pcen,
   output logic       irwrite,
   output logic       regwrite,
   output logic       iord,
   output logic       regdst,
   output logic       memtoreg,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsource,
   output logic [2:0] alucontrol,
   output logic       illegal,
   output logic       memfault,
   output logic [3:0] state
);

   localparam logic [TW-1:0] LP_WAIT_LIMIT = TW'(TIMEOUT_CYCLES - 1);

   state_t        r_state;
   state_t        w_nextState;
   logic [TW-1:0] r_wait;
   logic          w_memState;
   logic          w_timeout;
   logic          w_illegal;
   logic [2:0]    w_functAlu;
   logic          w_functValid;

   logic          w_memread, w_memwrite, w_pcen, w_irwrite, w_regwrite;
   logic          w_iord, w_regdst, w_memtoreg, w_alusrca;
   logic [1:0]    w_alusrcb, w_pcsource;
   logic [2:0]    w_alucontrol;

   mips_aludec u_aludec (
      .funct      (funct),
      .alucontrol (w_functAlu),
      .valid      (w_functValid)
   );

   // Only the three memory-handshake states count waiting cycles. memready
   // takes priority over an expiring count, so the timeout needs memready=0.
   assign w_memState = (r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR);
   assign w_timeout  = (TIMEOUT_CYCLES != 0) && w_memState && !memready
                       && (r_wait == LP_WAIT_LIMIT);

   // Next-state logic; illegal is raised in the same cycle the bad op/funct
   // is seen and the instruction is dropped back to FETCH.
   always_comb begin
      w_nextState = r_state;
      w_illegal   = 1'b0;
      case (r_state)
         FETCH: begin
            if (memready)       w_nextState = DECODE;
            else if (w_timeout) w_nextState = FETCH;
         end
         DECODE: begin
            case (op)
               OP_RTYPE:      w_nextState = RTYPEEX;
               OP_LW, OP_SW:  w_nextState = MEMADR;
               OP_BEQ:        w_nextState = BEQEX;
               OP_ADDI:       w_nextState = ADDIEX;
               OP_J:          w_nextState = JEX;
               default: begin
                  w_illegal   = 1'b1;
                  w_nextState = FETCH;
               end
            endcase
         end
         MEMADR:  w_nextState = (op == OP_SW) ? MEMWR : MEMRD;
         MEMRD: begin
            if (memready)       w_nextState = MEMWB;
            else if (w_timeout) w_nextState = FETCH;
         end
         MEMWB:   w_nextState = FETCH;
         MEMWR: begin
            if (memready || w_timeout) w_nextState = FETCH;
         end
         RTYPEEX: begin
            if (w_functValid) begin
               w_nextState = RTYPEWB;
            end else begin
               w_illegal   = 1'b1;
               w_nextState = FETCH;
            end
         end
         RTYPEWB: w_nextState = FETCH;
         BEQEX:   w_nextState = FETCH;
         ADDIEX:  w_nextState = ADDIWB;
         ADDIWB:  w_nextState = FETCH;
         JEX:     w_nextState = FETCH;
         default: w_nextState = FETCH;
      endcase
   end

   // State register and wait counter. The counter restarts on any
   // completion, timeout or state change, so each memory state (including a
   // re-entered FETCH after a timeout) begins counting from zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= FETCH;
         r_wait  <= '0;
      end else begin
         r_state <= w_nextState;
         if (w_memState && !memready && !w_timeout && (w_nextState == r_state))
            r_wait <= r_wait + 1'b1;
         else
            r_wait <= '0;
      end
   end

   // Output decode. Everything not mentioned for a state stays 0; pcen in
   // FETCH and BEQEX follows memready / zero combinationally.
   always_comb begin
      w_memread    = 1'b0;
      w_memwrite   = 1'b0;
      w_pcen       = 1'b0;
      w_irwrite    = 1'b0;
      w_regwrite   = 1'b0;
      w_iord       = 1'b0;
      w_regdst     = 1'b0;
      w_memtoreg   = 1'b0;
      w_alusrca    = 1'b0;
      w_alusrcb    = 2'b00;
      w_pcsource   = 2'b00;
      w_alucontrol = ALU_AND;
      case (r_state)
         FETCH: begin
            w_memread    = 1'b1;
            w_iord       = 1'b1;
            w_alusrcb    = 2'b01;
            w_alucontrol = ALU_ADD;
            w_irwrite    = memready;
            w_pcen       = memready;
         end
         DECODE: begin
            w_alusrcb    = 2'b11;
            w_alucontrol = ALU_ADD;
         end
         MEMADR, ADDIEX: begin
            w_alusrca    = 1'b1;
            w_alusrcb    = 2'b10;
            w_alucontrol = ALU_ADD;
         end
         MEMRD:   w_memread  = 1'b1;
         MEMWB: begin
            w_regwrite   = 1'b1;
            w_memtoreg   = 1'b1;
         end
         MEMWR:   w_memwrite = 1'b1;
         RTYPEEX: begin
            w_alusrca    = 1'b1;
            w_alucontrol = w_functAlu;
         end
         RTYPEWB: begin
            w_regwrite   = 1'b1;
            w_regdst     = 1'b1;
         end
         BEQEX: begin
            w_alusrca    = 1'b1;
            w_alucontrol = ALU_SUB;
            w_pcsource   = 2'b01;
            w_pcen       = zero;
         end
         ADDIWB:  w_regwrite = 1'b1;
         JEX: begin
            w_pcsource   = 2'b10;
            w_pcen       = 1'b1;
         end
         default: ;
      endcase
   end

   // Outputs are held at 0 for the whole time reset is low, even though the
   // state register already reads FETCH.
   assign memread    = reset & w_memread;
   assign memwrite   = reset & w_memwrite;
   assign pcen       = reset & w_pcen;
   assign irwrite    = reset & w_irwrite;
   assign regwrite   = reset & w_regwrite;
   assign iord       = reset & w_iord;
   assign regdst     = reset & w_regdst;
   assign memtoreg   = reset & w_memtoreg;
   assign alusrca    = reset & w_alusrca;
   assign alusrcb    = reset ? w_alusrcb    : 2'b00;
   assign pcsource   = reset ? w_pcsource   : 2'b00;
   assign alucontrol = reset ? w_alucontrol : 3'b000;
   assign illegal    = reset & w_illegal;
   assign memfault   = reset & w_timeout;
   assign state      = reset ? r_state : 4'd0;

endmodule

// File: tb/tb_mips_controller.sv
// ----------------------------------------------------------------------------
// tb_mips_controller
// Directed-vector bench for mips_controller, built with TIMEOUT_CYCLES=4.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ----------------------------------------------------------------------------
module tb_mips_controller;
   import mips_pkg::*;

   logic       clk;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       memready;
   logic       memread, memwrite, pcen, irwrite, regwrite;
   logic       iord, regdst, memtoreg, alusrca;
   logic [1:0] alusrcb, pcsource;
   logic [2:0] alucontrol;
   logic       illegal, memfault;
   logic [3:0] state;
   logic [17:0] obsCtrl;

   int checkCount = 0;
   int errorCount = 0;

   mips_controller #(.TIMEOUT_CYCLES(4), .TW(5)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .memready(memready), .memread(memread), .memwrite(memwrite),
      .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .iord(iord),
      .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
      .alusrcb(alusrcb), .pcsource(pcsource), .alucontrol(alucontrol),
      .illegal(illegal), .memfault(memfault), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign obsCtrl = {memread, memwrite, pcen, irwrite, regwrite, iord, regdst,
                     memtoreg, alusrca, alusrcb, pcsource, alucontrol,
                     illegal, memfault};

   // Hand-specified control word, same field order as obsCtrl.
   function automatic logic [17:0] cw(
      input logic mr, input logic mw, input logic pe, input logic irw,
      input logic rw, input logic io, input logic rd, input logic m2r,
      input logic asa, input logic [1:0] asb, input logic [1:0] pcs,
      input logic [2:0] alu, input logic ill, input logic mf);
      return {mr, mw, pe, irw, rw, io, rd, m2r, asa, asb, pcs, alu, ill, mf};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f,
                                input logic z, input logic rdy);
      op = o; funct = f; zero = z; memready = rdy;
   endtask

   // Check state + full control word for the current cycle, then advance.
   task automatic stepCheck(input string tag, input logic [3:0] expState,
                            input logic [17:0] expCtrl);
      #1;
      checkOutput({tag, "/state"}, 32'(state), 32'(expState));
      checkOutput({tag, "/ctrl"}, 32'(obsCtrl), 32'(expCtrl));
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0;
      applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
      #1;
      // memready=1 would raise pcen/irwrite in FETCH if not forced low.
      checkOutput("reset/state", 32'(state), 32'(FETCH));
      checkOutput("reset/ctrl", 32'(obsCtrl), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // LW with memory always ready: 5 cycles.
      stepCheck("lw-fetch",  FETCH,  cw(1,0,1,1,0,1,0,0,0,2'b01,2'b00,3'b010,0,0));
      stepCheck("lw-decode", DECODE, cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0));
      stepCheck("lw-memadr", MEMADR, cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0));
      stepCheck("lw-memrd",  MEMRD,  cw(1,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,0));
      stepCheck("lw-memwb",  MEMWB,  cw(0,0,0,0,1,0,0,1,0,2'b00,2'b00,3'b000,0,0));

      // R-type SUB.
      applyStimulus(OP_RTYPE, FN_SUB, 1'b0, 1'b1);
      stepCheck("sub-fetch", FETCH,   cw(1,0,1,1,0,1,0,0,0,2'b01,2'b00,3'b010,0,0));
      stepCheck("sub-dec",   DECODE,  cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0));
      stepCheck("sub-ex",    RTYPEEX, cw(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b110,0,0));
      stepCheck("sub-wb",    RTYPEWB, cw(0,0,0,0,1,0,1,0,0,2'b00,2'b00,3'b000,0,0));

      // R-type SLL shows another funct decode.
      applyStimulus(OP_RTYPE, FN_SLL, 1'b0, 1'b1);
      stepCheck("sll-fetch", FETCH,   cw(1,0,1,1,0,1,0,0,0,2'b01,2'b00,3'b010,0,0));
      stepCheck("sll-dec",   DECODE,  cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0));
      stepCheck("sll-ex",    RTYPEEX, cw(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b011,0,0));
      stepCheck("sll-wb",    RTYPEWB, cw(0,0,0,0,1,0,1,0,0,2'b00,2'b00,3'b000,0,0));

      // Unknown funct: illegal pulse in RTYPEEX, straight back to FETCH.
      applyStimulus(OP_RTYPE, 6'b111111, 1'b0, 1'b1);
      stepCheck("badfn-fetch", FETCH,  cw(1,0,1,1,0,1,0,0,0,2'b01,2'b00,3'b010,0,0));
      stepCheck("badfn-dec",   DECODE, cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0));
      #1;
      checkOutput("badfn-ex/state",    32'(state),    32'(RTYPEEX));
      checkOutput("badfn-ex/illegal",  32'(illegal),  32'd1);
      checkOutput("badfn-ex/regwrite", 32'(regwrite), 32'd0);
      @(negedge clk);
      #1;
      checkOutput("badfn-after/illegal", 32'(illegal), 32'd0);
      @(negedge clk);
      // The check above consumed a FETCH cycle with memready=1, so now DECODE.
      applyStimulus(OP_BEQ, 6'd0, 1'b1, 1'b1);
      stepCheck("beq1-dec", DECODE, cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0));
      stepCheck("beq1-ex",  BEQEX,  cw(0,0,1,0,0,0,0,0,1,2'b00,2'b01,3'b110,0,0));

      // BEQ not taken.
      applyStimulus(OP_BEQ, 6'd0, 1'b0, 1'b1);
      stepCheck("beq0-fetch", FETCH,  cw(1,0,1,1,0,1,0,0,0,2'b01,2'b00,3'b010,0,0));
      stepCheck("beq0-dec",   DECODE, cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0));
      stepCheck("beq0-ex",    BEQEX,  cw(0,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0,0));

      // ADDI and J.
      applyStimulus(OP_ADDI, 6'd0, 1'b0, 1'b1);
      stepCheck("addi-fetch", FETCH,  cw(1,0,1,1,0,1,0,0,0,2'b01,2'b00,3'b010,0,0));
      stepCheck("addi-dec",   DECODE, cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0));
      stepCheck("addi-ex",    ADDIEX, cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0));
      stepCheck("addi-wb",    ADDIWB, cw(0,0,0,0,1,0,0,0,0,2'b00,2'b00,3'b000,0,0));
      applyStimulus(OP_J, 6'd0, 1'b0, 1'b1);
      stepCheck("j-fetch", FETCH,  cw(1,0,1,1,0,1,0,0,0,2'b01,2'b00,3'b010,0,0));
      stepCheck("j-dec",   DECODE, cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0));
      stepCheck("j-ex",    JEX,    cw(0,0,1,0,0,0,0,0,0,2'b00,2'b10,3'b000,0,0));

      // SW: memready low for 3 MEMWR cycles, arrives on the timeout cycle.
      applyStimulus(OP_SW, 6'd0, 1'b0, 1'b1);
      stepCheck("sw-fetch", FETCH,  cw(1,0,1,1,0,1,0,0,0,2'b01,2'b00,3'b010,0,0));
      stepCheck("sw-dec",   DECODE, cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0));
      applyStimulus(OP_SW, 6'd0, 1'b0, 1'b0);
      stepCheck("sw-memadr", MEMADR, cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0));
      for (int i = 0; i < 3; i++)
         stepCheck("sw-wait", MEMWR, cw(0,1,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,0));
      applyStimulus(OP_SW, 6'd0, 1'b0, 1'b1);
      stepCheck("sw-done", MEMWR, cw(0,1,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,0));

      // LW whose read never completes: memfault on the 4th MEMRD cycle.
      applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
      stepCheck("lwto-fetch", FETCH,  cw(1,0,1,1,0,1,0,0,0,2'b01,2'b00,3'b010,0,0));
      stepCheck("lwto-dec",   DECODE, cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0));
      applyStimulus(OP_LW, 6'd0, 1'b0, 1'b0);
      stepCheck("lwto-memadr", MEMADR, cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0));
      for (int i = 0; i < 3; i++)
         stepCheck("lwto-wait", MEMRD, cw(1,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,0));
      stepCheck("lwto-fault", MEMRD, cw(1,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,1));

      // FETCH timeout, then FETCH re-entered with a fresh count.
      for (int i = 0; i < 3; i++)
         stepCheck("fto-wait", FETCH, cw(1,0,0,0,0,1,0,0,0,2'b01,2'b00,3'b010,0,0));
      stepCheck("fto-fault", FETCH, cw(1,0,0,0,0,1,0,0,0,2'b01,2'b00,3'b010,0,1));
      for (int i = 0; i < 3; i++)
         stepCheck("fto-rewait", FETCH, cw(1,0,0,0,0,1,0,0,0,2'b01,2'b00,3'b010,0,0));
      stepCheck("fto-refault", FETCH, cw(1,0,0,0,0,1,0,0,0,2'b01,2'b00,3'b010,0,1));

      // Unsupported opcode.
      applyStimulus(6'b111111, 6'd0, 1'b0, 1'b1);
      stepCheck("badop-fetch", FETCH,  cw(1,0,1,1,0,1,0,0,0,2'b01,2'b00,3'b010,0,0));
      stepCheck("badop-dec",   DECODE, cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,1,0));

      // Reset asserted while MEMRD is waiting.
      applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
      stepCheck("rst-fetch",  FETCH,  cw(1,0,1,1,0,1,0,0,0,2'b01,2'b00,3'b010,0,0));
      stepCheck("rst-dec",    DECODE, cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0));
      applyStimulus(OP_LW, 6'd0, 1'b0, 1'b0);
      stepCheck("rst-memadr", MEMADR, cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0));
      #1;
      checkOutput("rst-memrd/state", 32'(state), 32'(MEMRD));
      #1;
      reset = 1'b0;
      #1;
      checkOutput("rst-mid/state", 32'(state), 32'(FETCH));
      checkOutput("rst-mid/ctrl",  32'(obsCtrl), 32'd0);
      @(negedge clk);
      applyStimulus(OP_LW, 6'd0, 1'b0, 1'b1);
      #1;
      checkOutput("rst-hold/ctrl", 32'(obsCtrl), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      stepCheck("rst-rel-fetch", FETCH,  cw(1,0,1,1,0,1,0,0,0,2'b01,2'b00,3'b010,0,0));
      stepCheck("rst-rel-dec",   DECODE, cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0));

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/mips_controller.md
Name: mips_controller

Overview:
- Multicycle MIPS control unit; the control-side counterpart of mips_datapath.
- Consumes op/funct/zero from the datapath and drives every datapath select/enable.
- Sequences instructions through a Moore FSM and handshakes with off-processor memory via memready.
- Supports LW, SW, BEQ, ADDI, J, and R-type ADD/SUB/AND/OR/SLT/SLL/SRL.

Parameters:
TIMEOUT_CYCLES, 16, max cycles a memory state waits for memready before abort; 0 disables the timeout.
TW, 5, width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
op  in  6  instruction[31:26]
funct  in  6  instruction[5:0]
zero  in  1  ALU zero flag
memready  in  1  memory completed read/write this cycle
memread  out  1  memory read request
memwrite  out  1  memory write request
pcen  out  1  PC write enable (already branch-qualified)
irwrite  out  1  instruction register load
regwrite  out  1  register file write
iord  out  1  1 = address from PC, 0 = from ALUOut
regdst  out  1  1 = rd, 0 = rt
memtoreg  out  1  1 = MDR, 0 = ALUOut
alusrca  out  1  1 = A, 0 = PC
alusrcb  out  2  00 B, 01 const 1, 10/11 zero-extended imm
pcsource  out  2  00 ALU result, 01 ALUOut, 10 jump target
alucontrol  out  3  000 AND, 001 OR, 010 ADD, 011 SLL, 100 SRL, 110 SUB, 111 SLT
illegal  out  1  one-cycle pulse on an unsupported op or funct
memfault  out  1  one-cycle pulse on memory timeout
state  out  4  current state, for probing

Behaviour:
- Reset:
  - While reset=0: state=FETCH, wait counter=0, all outputs forced 0.
  - FETCH outputs become active in the first cycle after release.
- Outputs:
  - Combinational decode of the state register.
  - pcen additionally depends on zero and memready (Mealy terms).
  - All unlisted outputs are 0 in every state.
- PC word addressing: PC increments by 1; branch offset is imm, not imm<<2.
- FETCH:
  - Drives memread=1, iord=1, alusrca=0, alusrcb=01, alucontrol=ADD, pcsource=00.
  - irwrite=memready and pcen=memready.
  - Stays in FETCH until memready=1, then goes to DECODE.
- DECODE:
  - Drives alusrca=0, alusrcb=11, ADD, so ALUOut = PC+1+imm.
  - Next state by op: 000000 RTYPEEX; 100011/101011 MEMADR; 000100 BEQEX; 001000 ADDIEX; 000010 JEX.
  - Any other op: pulse illegal, go to FETCH.
- MEMADR: alusrca=1, alusrcb=10, ADD; next MEMRD (LW) or MEMWR (SW).
- MEMRD: memread=1, iord=0; waits for memready, then MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0; next FETCH.
- MEMWR: memwrite=1, iord=0; waits for memready, then FETCH.
- RTYPEEX:
  - Drives alusrca=1, alusrcb=00; alucontrol from funct:
    - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 000000 SLL, 000010 SRL.
  - Unknown funct: pulse illegal, go to FETCH with no register write.
  - Otherwise next RTYPEWB.
- RTYPEWB: regwrite=1, regdst=1, memtoreg=0; next FETCH.
- BEQEX: alusrca=1, alusrcb=00, SUB, pcsource=01, pcen=zero; next FETCH.
- ADDIEX: alusrca=1, alusrcb=10, ADD; next ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0; next FETCH.
- JEX: pcsource=10, pcen=1; next FETCH.
- Wait counter (FETCH, MEMRD, MEMWR only):
  - Clears on entering any of these states and on memready.
  - Otherwise increments each cycle.
  - When TIMEOUT_CYCLES≠0 and the count reaches TIMEOUT_CYCLES-1 with memready=0: pulse memfault, go to FETCH.
  - No regwrite, irwrite or pcen is asserted on a timeout.
  - A FETCH timeout re-enters FETCH with the counter cleared.
- memready arriving in the same cycle as the timeout: memready wins and completes normally.
- memready is ignored outside the three memory states.
- Reset asserted mid-instruction: immediate return to FETCH; outputs 0 while reset is low.

Decomposition:
- Package mips_pkg:
  - state enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
  - opcode localparams, funct localparams, alucontrol localparams.
- One sub-module, mips_aludec: funct → alucontrol plus a valid flag, purely combinational.

Test Plan:
- Reset release, memready held 1, op=100011:
  - FETCH→DECODE→MEMADR→MEMRD→MEMWB→FETCH, 5 cycles.
  - regwrite=1 and memtoreg=1 only in MEMWB.
- R-type funct=100010:
  - alucontrol=110 in RTYPEEX; regwrite=1 and regdst=1 in RTYPEWB.
  - funct=111111 → illegal pulse, no regwrite.
- BEQ:
  - zero=1 in BEQEX → pcen=1, pcsource=01.
  - zero=0 → pcen=0; next state FETCH in both cases.
- SW with memready low 3 cycles in MEMWR:
  - memwrite held 4 cycles, then FETCH.
  - TIMEOUT_CYCLES=4 with memready never asserted → memfault pulse on the 4th cycle, then FETCH.
- op=111111:
  - illegal pulse in DECODE, next FETCH.
  - reset driven low during MEMRD → all outputs 0 immediately, state=FETCH after release.
